msg_schedule: RTL and testbench

Sits directly downstream of the padder. Consumes padded 512-bit message beats: one beat per SHA-224/256 block, two consecutive beats per SHA-384/512 block. Expands each block into the W_t message-schedule word stream, one word per handshake, for the compression core. Supports both word sizes under sha_type control.

---
 rtl/msg_schedule.sv | 159 +++++++++++++++
 tb/tb_msg_schedule.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_schedule.sv
// SHA-2 message-schedule expander: turns padded 512-bit beats into the W_t word
// stream for the compression core, 32-bit words (SHA-224/256) or 64-bit (SHA-384/512).
module msg_schedule #(
  parameter int S_AXIS_DATA_WIDTH = 512,
  parameter int W_WIDTH           = 64
) (
  input  logic                         axi_aclk,
  input  logic                         axi_resetn,
  input  logic [1:0]                   sha_type,
  input  logic [S_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  output logic [W_WIDTH-1:0]           m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [6:0]                   m_round,
  output logic                         m_first
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_HI = 2'd1,
    EXPAND  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_mode;
  logic        r_blk_last;
  logic [6:0]  r_t;
  logic [63:0] r_w [16];

  logic        w_load_lo;
  logic        w_load_hi;
  logic        w_shift;
  logic        w_tready;
  logic        w_tvalid;
  logic        w_t_final;
  logic [31:0] w_sw32 [16];
  logic [63:0] w_sw64 [8];
  logic [31:0] w_next32;
  logic [63:0] w_next64;
  logic [63:0] w_next;
  logic        w_unused_sha_type0;

  assign w_unused_sha_type0 = sha_type[0];

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [63:0] bswap64(input logic [63:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24],
            x[39:32], x[47:40], x[55:48], x[63:56]};
  endfunction

  function automatic logic [31:0] sig0_32(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1_32(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic logic [63:0] sig0_64(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction

  function automatic logic [63:0] sig1_64(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction

  // Input beat unpacking: byte 0 of each word is its most significant byte
  always_comb begin
    for (int j = 0; j < 16; j++) w_sw32[j] = bswap32(s_axis_tdata[32*j +: 32]);
    for (int j = 0; j < 8; j++)  w_sw64[j] = bswap64(s_axis_tdata[64*j +: 64]);
  end

  assign w_next32 = sig1_32(r_w[14][31:0]) + r_w[9][31:0]
                  + sig0_32(r_w[1][31:0]) + r_w[0][31:0];
  assign w_next64 = sig1_64(r_w[14]) + r_w[9] + sig0_64(r_w[1]) + r_w[0];
  assign w_next   = r_mode ? w_next64 : {32'd0, w_next32};
  assign w_t_final = (r_t == (r_mode ? 7'd79 : 7'd63));

  always_comb begin
    w_state_nxt = r_state;
    w_load_lo   = 1'b0;
    w_load_hi   = 1'b0;
    w_shift     = 1'b0;
    w_tready    = 1'b0;
    w_tvalid    = 1'b0;
    case (r_state)
      IDLE: begin
        w_tready = 1'b1;
        if (s_axis_tvalid) begin
          w_load_lo   = 1'b1;
          w_state_nxt = sha_type[1] ? LOAD_HI : EXPAND;
        end
      end
      LOAD_HI: begin
        w_tready = 1'b1;
        if (s_axis_tvalid) begin
          w_load_hi   = 1'b1;
          w_state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        w_tvalid = 1'b1;
        if (m_axis_tready) begin
          w_shift = 1'b1;
          if (w_t_final) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Both handshakes are masked during reset so nothing transfers in the reset cycle
  assign s_axis_tready = axi_resetn & w_tready;
  assign m_axis_tvalid = axi_resetn & w_tvalid;
  assign m_axis_tdata  = W_WIDTH'(r_w[0]);
  assign m_axis_tlast  = m_axis_tvalid & r_blk_last & w_t_final;
  assign m_round       = axi_resetn ? r_t : 7'd0;
  assign m_first       = m_axis_tvalid & (r_t == 7'd0);

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      r_state    <= IDLE;
      r_t        <= 7'd0;
      r_mode     <= 1'b0;
      r_blk_last <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_lo) begin
        r_mode     <= sha_type[1];
        r_blk_last <= s_axis_tlast;
      end
      if (w_load_hi) r_blk_last <= r_blk_last | s_axis_tlast;
      if (w_shift) r_t <= w_t_final ? 7'd0 : r_t + 7'd1;
    end
  end

  // Sliding 16-word window; in 32-bit mode the upper halves stay zero
  always_ff @(posedge axi_aclk) begin
    if (w_load_lo && !sha_type[1]) begin
      for (int j = 0; j < 16; j++) r_w[j] <= {32'd0, w_sw32[j]};
    end else if (w_load_lo) begin
      for (int j = 0; j < 8; j++) r_w[j] <= w_sw64[j];
    end else if (w_load_hi) begin
      for (int j = 0; j < 8; j++) r_w[j+8] <= w_sw64[j];
    end else if (w_shift) begin
      for (int k = 0; k < 15; k++) r_w[k] <= r_w[k+1];
      r_w[15] <= w_next;
    end
  end

endmodule

// File: tb/tb_msg_schedule.sv
// Directed bench for msg_schedule: known SHA-2 "abc" schedule words, stalls,
// back-to-back blocks, mid-block reset and mode switching.
module tb_msg_schedule;
  logic         axi_aclk = 1'b0;
  logic         axi_resetn = 1'b0;
  logic [1:0]   sha_type = 2'b00;
  logic [511:0] s_axis_tdata = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic         s_axis_tlast = 1'b0;
  logic [63:0]  m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;
  logic         m_axis_tlast;
  logic [6:0]   m_round;
  logic         m_first;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_w [0:79];
  logic [63:0] got_w [0:79];

  msg_schedule dut (
    .axi_aclk(axi_aclk), .axi_resetn(axi_resetn), .sha_type(sha_type),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_round(m_round), .m_first(m_first)
  );

  always #5 axi_aclk = ~axi_aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge axi_aclk);
    #1;
  endtask

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference schedule from the textbook recurrence over the full W array
  task automatic build_exp(input logic [511:0] b0, input logic [511:0] b1, input bit mode);
    logic [7:0]  by [0:127];
    logic [31:0] w32 [0:63];
    logic [63:0] w64 [0:79];
    for (int i = 0; i < 64; i++) begin
      by[i]      = b0[8*i +: 8];
      by[64 + i] = b1[8*i +: 8];
    end
    if (!mode) begin
      for (int j = 0; j < 16; j++) w32[j] = {by[4*j], by[4*j+1], by[4*j+2], by[4*j+3]};
      for (int t = 16; t < 64; t++)
        w32[t] = (rotr32(w32[t-2], 17) ^ rotr32(w32[t-2], 19) ^ (w32[t-2] >> 10))
               + w32[t-7]
               + (rotr32(w32[t-15], 7) ^ rotr32(w32[t-15], 18) ^ (w32[t-15] >> 3))
               + w32[t-16];
      for (int t = 0; t < 64; t++) exp_w[t] = {32'd0, w32[t]};
    end else begin
      for (int j = 0; j < 16; j++)
        w64[j] = {by[8*j], by[8*j+1], by[8*j+2], by[8*j+3],
                  by[8*j+4], by[8*j+5], by[8*j+6], by[8*j+7]};
      for (int t = 16; t < 80; t++)
        w64[t] = (rotr64(w64[t-2], 19) ^ rotr64(w64[t-2], 61) ^ (w64[t-2] >> 6))
               + w64[t-7]
               + (rotr64(w64[t-15], 1) ^ rotr64(w64[t-15], 8) ^ (w64[t-15] >> 7))
               + w64[t-16];
      for (int t = 0; t < 80; t++) exp_w[t] = w64[t];
    end
  endtask

  function automatic logic [511:0] pat_beat(input int mul, input int add);
    logic [511:0] b;
    for (int i = 0; i < 64; i++) b[8*i +: 8] = 8'((i * mul + add) & 8'hff);
    return b;
  endfunction

  task automatic send_beat(input logic [511:0] d, input bit last, input logic [1:0] typ,
                           input string nm);
    int n;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    sha_type      = typ;
    s_axis_tvalid = 1'b1;
    n = 0;
    while (s_axis_tready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: s_axis_tready=%b required 1", nm, s_axis_tready);
    end
    step();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic collect(input int n, input bit last, input bit stall, input bit post,
                         input string nm);
    int idx, idle;
    logic [63:0] hd;
    logic [6:0]  hr;
    logic        hl, held;
    idx = 0; idle = 0; held = 1'b0;
    hd = '0; hr = '0; hl = 1'b0;
    while (idx < n && idle < 50) begin
      if (held) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hd || m_round !== hr || m_axis_tlast !== hl) begin
          errors++;
          $display("FAIL %s stall hold: vld=%b data=%h round=%0d last=%b required 1 %h %0d %b",
                   nm, m_axis_tvalid, m_axis_tdata, m_round, m_axis_tlast, hd, hr, hl);
        end
      end
      m_axis_tready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      held = 1'b0;
      if (m_axis_tvalid === 1'b1) begin
        if (m_axis_tready) begin
          got_w[idx] = m_axis_tdata;
          checks++;
          if (m_axis_tdata !== exp_w[idx]) begin
            errors++;
            $display("FAIL %s W%0d: got %h required %h", nm, idx, m_axis_tdata, exp_w[idx]);
          end
          checks++;
          if (m_round !== 7'(idx)) begin
            errors++;
            $display("FAIL %s round: got %0d required %0d", nm, m_round, idx);
          end
          checks++;
          if (m_axis_tlast !== (last && idx == n - 1)) begin
            errors++;
            $display("FAIL %s tlast at W%0d: got %b required %b", nm, idx, m_axis_tlast,
                     (last && idx == n - 1));
          end
          checks++;
          if (m_first !== (idx == 0)) begin
            errors++;
            $display("FAIL %s first at W%0d: got %b required %b", nm, idx, m_first, (idx == 0));
          end
          checks++;
          if (s_axis_tready !== 1'b0) begin
            errors++;
            $display("FAIL %s s_tready during expand W%0d: got %b required 0", nm, idx, s_axis_tready);
          end
          idx++;
          idle = 0;
        end else begin
          held = 1'b1;
          hd = m_axis_tdata; hr = m_round; hl = m_axis_tlast;
        end
      end else begin
        idle++;
      end
      step();
    end
    checks++;
    if (idx != n) begin
      errors++;
      $display("FAIL %s word count: got %0d required %0d", nm, idx, n);
    end
    if (post) begin
      checks++;
      if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
        errors++;
        $display("FAIL %s after last word: m_tvalid=%b s_tready=%b required 0 1",
                 nm, m_axis_tvalid, s_axis_tready);
      end
    end
  endtask

  task automatic test_reset();
    axi_resetn = 1'b0;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    step(); step();
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_first !== 1'b0 ||
        m_round !== 7'd0 || s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL reset values: vld=%b last=%b first=%b round=%0d s_rdy=%b required 0 0 0 0 0",
               m_axis_tvalid, m_axis_tlast, m_first, m_round, s_axis_tready);
    end
    s_axis_tvalid = 1'b0;
    axi_resetn = 1'b1;
    step();
    checks++;
    if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset release: s_rdy=%b vld=%b required 1 0", s_axis_tready, m_axis_tvalid);
    end
  endtask

  task automatic test_sha256_abc();
    logic [511:0] b;
    b = '0;
    b[31:0]    = 32'h80636261;
    b[511:504] = 8'h18;
    build_exp(b, '0, 1'b0);
    send_beat(b, 1'b1, 2'b00, "abc256");
    checks++;
    if (m_axis_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL abc256 W0 latency: vld=%b required 1", m_axis_tvalid);
    end
    collect(64, 1'b1, 1'b0, 1'b1, "abc256");
    checks++;
    if (got_w[0] !== 64'h61626380 || got_w[1] !== 64'h0 || got_w[14] !== 64'h0 ||
        got_w[15] !== 64'h18 || got_w[16] !== 64'h61626380 || got_w[17] !== 64'h000F0000) begin
      errors++;
      $display("FAIL abc256 known words: W0=%h W15=%h W16=%h W17=%h required 61626380 18 61626380 000f0000",
               got_w[0], got_w[15], got_w[16], got_w[17]);
    end
  endtask

  task automatic test_sha512_abc();
    logic [511:0] b0, b1;
    b0 = '0;
    b0[31:0] = 32'h80636261;
    b1 = '0;
    b1[511:504] = 8'h18;
    build_exp(b0, b1, 1'b1);
    send_beat(b0, 1'b0, 2'b10, "abc512_b0");
    checks++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL abc512 load_hi: vld=%b s_rdy=%b required 0 1", m_axis_tvalid, s_axis_tready);
    end
    send_beat(b1, 1'b1, 2'b00, "abc512_b1");
    checks++;
    if (m_axis_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL abc512 W0 latency: vld=%b required 1", m_axis_tvalid);
    end
    collect(80, 1'b1, 1'b0, 1'b1, "abc512");
    checks++;
    if (got_w[0] !== 64'h6162638000000000 || got_w[15] !== 64'h18 ||
        got_w[16] !== 64'h6162638000000000 || got_w[17] !== 64'h00030000000000C0) begin
      errors++;
      $display("FAIL abc512 known words: W0=%h W15=%h W16=%h W17=%h required 6162638000000000 18 6162638000000000 00030000000000c0",
               got_w[0], got_w[15], got_w[16], got_w[17]);
    end
  endtask

  task automatic test_stall();
    logic [511:0] b;
    b = pat_beat(7, 3);
    build_exp(b, '0, 1'b0);
    send_beat(b, 1'b1, 2'b00, "stall");
    collect(64, 1'b1, 1'b1, 1'b1, "stall");
    checks++;
    if (got_w[0] !== 64'h030A1118) begin
      errors++;
      $display("FAIL stall W0 byte order: got %h required 00000000030a1118", got_w[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [511:0] b1, b2;
    b1 = pat_beat(13, 1);
    b2 = pat_beat(29, 200);
    build_exp(b1, '0, 1'b0);
    send_beat(b1, 1'b0, 2'b00, "b2b_blk1");
    s_axis_tdata  = b2;
    s_axis_tlast  = 1'b1;
    s_axis_tvalid = 1'b1;
    collect(64, 1'b0, 1'b0, 1'b1, "b2b_blk1");
    step();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    build_exp(b2, '0, 1'b0);
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_round !== 7'd0) begin
      errors++;
      $display("FAIL b2b block2 start: vld=%b round=%0d required 1 0", m_axis_tvalid, m_round);
    end
    collect(64, 1'b1, 1'b0, 1'b1, "b2b_blk2");
  endtask

  task automatic test_reset_mid();
    logic [511:0] b;
    b = pat_beat(11, 5);
    build_exp(b, '0, 1'b0);
    send_beat(b, 1'b1, 2'b00, "rstmid");
    collect(30, 1'b0, 1'b0, 1'b0, "rstmid_pre");
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_round !== 7'd30) begin
      errors++;
      $display("FAIL rstmid at round 30: vld=%b round=%0d required 1 30", m_axis_tvalid, m_round);
    end
    m_axis_tready = 1'b1;
    axi_resetn = 1'b0;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0 || m_round !== 7'd0) begin
      errors++;
      $display("FAIL rstmid reset cycle: vld=%b s_rdy=%b round=%0d required 0 0 0",
               m_axis_tvalid, s_axis_tready, m_round);
    end
    step();
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid after reset edge: vld=%b required 0", m_axis_tvalid);
    end
    axi_resetn = 1'b1;
    step();
    checks++;
    if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid release: s_rdy=%b vld=%b required 1 0", s_axis_tready, m_axis_tvalid);
    end
    b = '0;
    b[31:0]    = 32'h80636261;
    b[511:504] = 8'h18;
    build_exp(b, '0, 1'b0);
    send_beat(b, 1'b1, 2'b00, "rstmid_new");
    collect(64, 1'b1, 1'b0, 1'b1, "rstmid_new");
  endtask

  task automatic test_mode_switch();
    logic [511:0] a, b0, b1;
    logic [31:0]  hi_or;
    a  = pat_beat(37, 9);
    b0 = pat_beat(3, 250);
    b1 = pat_beat(17, 77);
    build_exp(a, '0, 1'b0);
    send_beat(a, 1'b0, 2'b01, "switch256");
    collect(64, 1'b0, 1'b1, 1'b1, "switch256");
    hi_or = '0;
    for (int i = 0; i < 64; i++) hi_or = hi_or | got_w[i][63:32];
    checks++;
    if (hi_or !== 32'd0) begin
      errors++;
      $display("FAIL switch256 upper bits: got %h required 00000000", hi_or);
    end
    build_exp(b0, b1, 1'b1);
    send_beat(b0, 1'b0, 2'b11, "switch512_b0");
    send_beat(b1, 1'b1, 2'b01, "switch512_b1");
    collect(80, 1'b1, 1'b0, 1'b1, "switch512");
  endtask

  initial begin
    test_reset();
    test_sha256_abc();
    test_sha512_abc();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_mode_switch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
